// File: rtl/seg7_pkg.sv
// seg7_pkg: hex-to-segment table, segment bit positions and output polarity helper.
package seg7_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Active-high {g,f,e,d,c,b,a} patterns for 0-F
    localparam logic [6:0] HEX_SEG [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] seg_pol(input logic [6:0] s, input logic inv);
        return inv ? ~s : s;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational nibble to active-high 7-segment pattern, all off when blanked.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    logic [6:0] pat;

    assign pat   = blank_i ? 7'd0 : HEX_SEG[nib_i];
    assign seg_o = {pat[SEG_G], pat[SEG_F], pat[SEG_E], pat[SEG_D], pat[SEG_C], pat[SEG_B], pat[SEG_A]};

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed common-anode display scanner with frame-synchronous
// value update, leading-zero blanking, per-digit DP and anode guard interval.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int GUARD          = 2,
    parameter bit ACTIVE_LOW_SEG = 1,
    parameter bit ACTIVE_LOW_AN  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  blank_lz,
    input  logic [DIGITS-1:0]     dp_mask,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int DW = $clog2(DIGITS);
    localparam logic [DIGITS-1:0] AN_OFF  = ACTIVE_LOW_AN ? '1 : '0;
    localparam logic [DIGITS-1:0] AN_ONE  = 1;
    localparam logic [6:0]        SEG_OFF = seg_pol(7'd0, ACTIVE_LOW_SEG);

    logic [PW-1:0]       pre_q, pre_d;
    logic [DW-1:0]       dig_q, dig_d;
    logic [4*DIGITS-1:0] pend_q, pend_d, disp_q, disp_d;
    logic                pv_q, pv_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [6:0]          seg_q, seg_d, seg_raw;
    logic                dp_q, dp_d, fd_q;
    logic                tick, boundary, blank;
    logic [DIGITS-1:0]   lz;

    assign tick     = pre_q == PW'(REFRESH_DIV - 1);
    assign boundary = tick && dig_q == DW'(DIGITS - 1);
    assign pre_d    = tick ? '0 : pre_q + 1'b1;
    assign dig_d    = !tick ? dig_q : boundary ? '0 : dig_q + 1'b1;

    // A load at the boundary bypasses the pending buffer so the newest value wins
    assign pend_d = (load && !boundary) ? value : pend_q;
    assign pv_d   = !boundary && (load || pv_q);
    assign disp_d = !boundary ? disp_q : load ? value : pv_q ? pend_q : disp_q;

    for (genvar i = 0; i < DIGITS; i++) begin : g_lz
        assign lz[i] = ~|disp_q[4*DIGITS-1:4*i];
    end

    assign blank = blank_lz && dig_q != '0 && lz[dig_q];

    seg7_hex_decode u_dec (
        .nib_i   (disp_q[{dig_q, 2'b00} +: 4]),
        .blank_i (blank),
        .seg_o   (seg_raw)
    );

    assign seg_d = seg_pol(seg_raw, ACTIVE_LOW_SEG);
    assign an_d  = ((pre_q >= PW'(GUARD)) ? (AN_ONE << dig_q) : '0) ^ AN_OFF;
    assign dp_d  = dp_mask[dig_q] ^ ACTIVE_LOW_SEG;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q  <= '0;
            dig_q  <= '0;
            pend_q <= '0;
            pv_q   <= 1'b0;
            disp_q <= '0;
            an_q   <= AN_OFF;
            seg_q  <= SEG_OFF;
            dp_q   <= ACTIVE_LOW_SEG;
            fd_q   <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            dig_q  <= dig_d;
            pend_q <= pend_d;
            pv_q   <= pv_d;
            disp_q <= disp_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            fd_q   <= boundary;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed table-driven bench for seg7_scan_driver
// (DIGITS=4, REFRESH_DIV=8, GUARD=2, active-low segments and anodes).
module tb_seg7_scan_driver;

    logic        clk = 1'b0, reset = 1'b0, load = 1'b0, blank_lz = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_mask = '0, an;
    logic [6:0]  seg;
    logic        dp, frame_done;
    int          n_cmp = 0, n_bad = 0;

    typedef struct {
        int         k;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    typedef struct {
        int          k;
        logic        ld;
        logic [15:0] v;
        logic        bl;
        logic [3:0]  dpm;
    } ev_t;

    exp_t exps[$];
    ev_t  evs[$];

    seg7_scan_driver #(
        .DIGITS(4), .REFRESH_DIV(8), .GUARD(2), .ACTIVE_LOW_SEG(1), .ACTIVE_LOW_AN(1)
    ) dut (
        .clk(clk), .reset(reset), .load(load), .value(value), .blank_lz(blank_lz),
        .dp_mask(dp_mask), .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    initial begin
        int         pre, dig, run;
        logic [3:0] ea;
        logic       ed;
        // k = clock edge after reset release; outputs sampled on the following negedge
        exps.push_back('{20,  4'b1011, 7'b1000000, 1'b1, 1'b0});
        exps.push_back('{28,  4'b0111, 7'b1000000, 1'b1, 1'b0});
        exps.push_back('{32,  4'b0111, 7'b1000000, 1'b1, 1'b1});
        exps.push_back('{33,  4'b1111, 7'b0011001, 1'b1, 1'b0});
        exps.push_back('{36,  4'b1110, 7'b0011001, 1'b1, 1'b0});
        exps.push_back('{44,  4'b1101, 7'b0110000, 1'b1, 1'b0});
        exps.push_back('{52,  4'b1011, 7'b0100100, 1'b1, 1'b0});
        exps.push_back('{60,  4'b0111, 7'b1111001, 1'b1, 1'b0});
        exps.push_back('{64,  4'b0111, 7'b1111001, 1'b1, 1'b1});
        exps.push_back('{68,  4'b1110, 7'b1000000, 1'b1, 1'b0});
        exps.push_back('{76,  4'b1101, 7'b0011001, 1'b1, 1'b0});
        exps.push_back('{84,  4'b1011, 7'b1111111, 1'b1, 1'b0});
        exps.push_back('{92,  4'b0111, 7'b1111111, 1'b1, 1'b0});
        exps.push_back('{100, 4'b1110, 7'b1000000, 1'b1, 1'b0});
        exps.push_back('{108, 4'b1101, 7'b1111111, 1'b1, 1'b0});
        exps.push_back('{116, 4'b1011, 7'b1111111, 1'b1, 1'b0});
        exps.push_back('{124, 4'b0111, 7'b1111111, 1'b1, 1'b0});
        exps.push_back('{128, 4'b0111, 7'b1111111, 1'b1, 1'b1});
        exps.push_back('{129, 4'b1111, 7'b0100001, 1'b1, 1'b0});
        exps.push_back('{132, 4'b1110, 7'b0100001, 1'b1, 1'b0});
        exps.push_back('{140, 4'b1101, 7'b1000110, 1'b1, 1'b0});
        exps.push_back('{148, 4'b1011, 7'b0000011, 1'b1, 1'b0});
        exps.push_back('{156, 4'b0111, 7'b0001000, 1'b1, 1'b0});
        exps.push_back('{164, 4'b1110, 7'b0100001, 1'b1, 1'b0});
        exps.push_back('{188, 4'b0111, 7'b0001000, 1'b1, 1'b0});
        exps.push_back('{196, 4'b1110, 7'b0100100, 1'b1, 1'b0});
        // Input applied after the sample at k, captured on edge k+1
        evs.push_back('{11,  1'b1, 16'h1234, 1'b0, 4'b0000});
        evs.push_back('{39,  1'b1, 16'h0040, 1'b1, 4'b0000});
        evs.push_back('{69,  1'b1, 16'h0000, 1'b1, 4'b0000});
        evs.push_back('{109, 1'b1, 16'h5555, 1'b1, 4'b0000});
        evs.push_back('{127, 1'b1, 16'hABCD, 1'b1, 4'b0000});
        evs.push_back('{169, 1'b1, 16'h1111, 1'b1, 4'b0000});
        evs.push_back('{179, 1'b1, 16'h2222, 1'b1, 4'b0000});
        evs.push_back('{192, 1'b0, 16'h0000, 1'b1, 4'b0100});
        repeat (5) @(negedge clk);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'd1);
        chk("rst_fd", 32'(frame_done), 32'd0);
        dp_mask = 4'b0100;
        reset = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 2) chk("rel_k2_an", 32'(an), 32'hF);
            if (k == 3) begin
                chk("rel_k3_an", 32'(an), 32'b1110);
                chk("rel_k3_seg", 32'(seg), 32'b1000000);
            end
        end
        chk("mid_an", 32'(an), 32'b1011);
        chk("mid_dp", 32'(dp), 32'd0);
        chk("mid_seg", 32'(seg), 32'b1000000);
        #2 reset = 1'b0;
        #1;
        chk("arst_an", 32'(an), 32'hF);
        chk("arst_seg", 32'(seg), 32'h7F);
        chk("arst_dp", 32'(dp), 32'd1);
        dp_mask = 4'b0000;
        repeat (2) @(negedge clk);
        chk("hold_an", 32'(an), 32'hF);
        reset = 1'b1;
        run = 0;
        for (int k = 1; k <= 320; k++) begin
            @(negedge clk);
            foreach (exps[i]) begin
                if (exps[i].k == k) begin
                    chk($sformatf("k%0d_an", k), 32'(an), 32'(exps[i].an));
                    chk($sformatf("k%0d_seg", k), 32'(seg), 32'(exps[i].seg));
                    chk($sformatf("k%0d_dp", k), 32'(dp), 32'(exps[i].dp));
                    chk($sformatf("k%0d_fd", k), 32'(frame_done), 32'(exps[i].fd));
                end
            end
            if (k >= 193) begin
                pre = (k - 1) % 8;
                dig = ((k - 1) / 8) % 4;
                ea  = (pre >= 2) ? ~(4'b0001 << dig) : 4'hF;
                ed  = (dig == 2) ? 1'b0 : 1'b1;
                chk($sformatf("sw%0d_an", k), 32'(an), 32'(ea));
                chk($sformatf("sw%0d_onehot", k), 32'($countones(~an) <= 1), 32'd1);
                chk($sformatf("sw%0d_seg", k), 32'(seg), 32'b0100100);
                chk($sformatf("sw%0d_dp", k), 32'(dp), 32'(ed));
                chk($sformatf("sw%0d_fd", k), 32'(frame_done), 32'(k % 32 == 0));
                if (an != 4'hF) run++;
                else begin
                    if (run != 0) chk($sformatf("sw%0d_runlen", k), 32'(run), 32'd6);
                    run = 0;
                end
            end
            load = 1'b0;
            foreach (evs[i]) begin
                if (evs[i].k == k) begin
                    load     = evs[i].ld;
                    value    = evs[i].v;
                    blank_lz = evs[i].bl;
                    dp_mask  = evs[i].dpm;
                end
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
